// File: rtl/simd_pkg.sv
// Shared SIMD definitions: comparison-unit fn codes, reduction modes and
// the reduction controller state encoding.
package simd_pkg;

  localparam logic [3:0] CMP_EQ  = 4'd0;
  localparam logic [3:0] CMP_NEQ = 4'd1;
  localparam logic [3:0] CMP_GT  = 4'd2;
  localparam logic [3:0] CMP_GTE = 4'd3;
  localparam logic [3:0] CMP_LT  = 4'd4;
  localparam logic [3:0] CMP_LTE = 4'd5;
  localparam logic [3:0] CMP_NOP = 4'b1111;

  localparam logic REDUCE_MAX = 1'b0;
  localparam logic REDUCE_MIN = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } reduce_state_t;

  // Strict comparison so that ties never displace the earlier element.
  function automatic logic [3:0] reduce_fn(input logic mode);
    return (mode == REDUCE_MIN) ? CMP_LT : CMP_GT;
  endfunction

endpackage

// File: rtl/simd_compare_reduce_ctrl.sv
// Streams a vector through the shared signed comparison unit and reports the
// max (or min) element together with its zero-based index.
module simd_compare_reduce_ctrl
  import simd_pkg::*;
#(
  parameter int BIT_WIDTH     = 32,
  parameter int FUNCTION_BITS = 4,
  parameter int LEN_BITS      = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     mode,
  input  logic [LEN_BITS-1:0]      len,
  output logic                     busy,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BIT_WIDTH-1:0]     in_data,
  output logic [FUNCTION_BITS-1:0] cmp_fn,
  output logic [BIT_WIDTH-1:0]     cmp_in0,
  output logic [BIT_WIDTH-1:0]     cmp_in1,
  input  logic [BIT_WIDTH-1:0]     cmp_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BIT_WIDTH-1:0]     out_value,
  output logic [LEN_BITS-1:0]      out_index,
  output logic                     out_empty
);

  reduce_state_t               state;
  logic                        mode_r;
  logic [LEN_BITS-1:0]         len_r;
  logic [LEN_BITS-1:0]         count;
  logic [LEN_BITS-1:0]         best_idx;
  logic signed [BIT_WIDTH-1:0] best;
  logic                        empty_r;
  logic                        cmp_unused;

  // Only bit 0 of the unit's output carries the comparison outcome.
  assign cmp_unused = ^cmp_result[BIT_WIDTH-1:1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      mode_r   <= REDUCE_MAX;
      len_r    <= '0;
      count    <= '0;
      best_idx <= '0;
      best     <= '0;
      empty_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mode_r <= mode;
            len_r  <= len;
            count  <= '0;
            if (len == '0) begin
              best     <= '0;
              best_idx <= '0;
              empty_r  <= 1'b1;
              state    <= DONE;
            end else begin
              state <= FIRST;
            end
          end
        end
        FIRST: begin
          if (in_valid) begin
            best     <= in_data;
            best_idx <= '0;
            count    <= LEN_BITS'(1);
            empty_r  <= 1'b0;
            state    <= (len_r == LEN_BITS'(1)) ? DONE : SCAN;
          end
        end
        SCAN: begin
          if (in_valid) begin
            if (cmp_result[0]) begin
              best     <= in_data;
              best_idx <= count;
            end
            // Count parks on the last index rather than running past len-1.
            if (count == len_r - LEN_BITS'(1)) state <= DONE;
            else                               count <= count + LEN_BITS'(1);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign in_ready  = (state == FIRST) || (state == SCAN);
  assign out_valid = (state == DONE);
  assign out_value = best;
  assign out_index = best_idx;
  assign out_empty = empty_r;

  // Operands are presented only while scanning; otherwise the unit sees NOP.
  always_comb begin
    cmp_fn  = FUNCTION_BITS'(CMP_NOP);
    cmp_in0 = '0;
    cmp_in1 = '0;
    if (state == SCAN) begin
      cmp_fn  = FUNCTION_BITS'(reduce_fn(mode_r));
      cmp_in0 = in_data;
      cmp_in1 = best;
    end
  end

endmodule
